// File: rtl/mem_responder.sv
// Memory-side responder for the processor bus: tags requests on acceptance and returns
// load data through a fixed-latency completion pipeline.
module mem_responder #(
    parameter int unsigned MEM_LATENCY     = 4,
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned XLEN            = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH_WORDS);

    typedef enum logic [1:0] {
        BusNone  = 2'd0,
        BusLoad  = 2'd1,
        BusStore = 2'd2
    } bus_cmd_e;

    logic [63:0]     mem_q       [MEM_DEPTH_WORDS];
    logic [3:0]      tag_pipe_q  [MEM_LATENCY];
    logic [63:0]     data_pipe_q [MEM_LATENCY];
    logic [3:0]      next_tag_q, next_tag_d;
    logic [IdxW-1:0] word_idx;
    logic            is_load, is_store, accept;

    // Byte offset and bits above the backed range are deliberately dropped (aliasing).
    assign word_idx = proc2mem_addr[3 +: IdxW];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc2mem_addr[XLEN-1:IdxW+3], proc2mem_addr[2:0]};

    always_comb begin
        is_load           = !reset && (proc2mem_command == BusLoad);
        is_store          = !reset && (proc2mem_command == BusStore);
        accept            = is_load || is_store;
        mem2proc_response = accept ? next_tag_q : 4'd0;
        next_tag_d        = next_tag_q;
        if (accept) begin
            // Tag 0 means "not accepted", so the counter skips it on wrap.
            next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag_q <= 4'd1;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                tag_pipe_q[i]  <= 4'd0;
                data_pipe_q[i] <= 64'd0;
            end
        end else begin
            next_tag_q     <= next_tag_d;
            tag_pipe_q[0]  <= is_load ? next_tag_q : 4'd0;
            data_pipe_q[0] <= is_load ? mem_q[word_idx] : 64'd0;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tag_pipe_q[i]  <= tag_pipe_q[i-1];
                data_pipe_q[i] <= data_pipe_q[i-1];
            end
        end
    end

    // Storage survives reset so stores remain visible afterwards.
    always_ff @(posedge clock) begin
        if (is_store) begin
            mem_q[word_idx] <= proc2mem_data;
        end
    end

    assign mem2proc_tag  = tag_pipe_q[MEM_LATENCY-1];
    assign mem2proc_data = data_pipe_q[MEM_LATENCY-1];

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Synthesizable memory-side responder for the processor memory bus. It answers the single request stream produced by the I/D cache controller: BUS_LOAD/BUS_STORE commands are acknowledged with a transaction tag in the request cycle, and load data is returned tagged a fixed number of cycles later. It stands in for main memory in the processor testbench and in cache/controller unit benches.

Parameters:
MEM_LATENCY, 4, cycles from request acceptance to load completion; legal range 1..14.
MEM_DEPTH_WORDS, 1024, number of 64-bit words backed by storage; power of two.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
proc2mem_command  input  2  BUS_NONE / BUS_LOAD / BUS_STORE; encoding 3 is invalid
proc2mem_addr  input  XLEN  byte address of the request
proc2mem_data  input  64  store data
mem2proc_response  output  4  acceptance tag, combinational; 0 = not accepted
mem2proc_data  output  64  load completion data, registered
mem2proc_tag  output  4  completion tag, registered; 0 = no completion this cycle

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: mem2proc_tag=0, mem2proc_data=0, next_tag=1, completion pipeline emptied.
- Reset does not clear the storage array. Contents are undefined until written.
- mem2proc_response:
  - Forced to 0 while reset is high.
  - 0 for BUS_NONE and for command 3.
  - Otherwise equals next_tag in the same cycle the command is presented.
- Accepted request: next_tag advances at the clock edge, 1→2→…→15→1. It never takes the value 0.
- Rejected or idle cycles leave next_tag unchanged.
- Word index = proc2mem_addr[3 +: log2(MEM_DEPTH_WORDS)].
  - Bits [2:0] are ignored, so accesses are 8-byte aligned.
  - Higher address bits are ignored, so addresses alias and wrap.
- Store: proc2mem_data is written to the indexed word at the accepting edge. A store produces no completion; its tag is never returned on mem2proc_tag.
- Load:
  - The indexed word is read at the accepting edge.
  - A store accepted in an earlier cycle is visible to the load.
  - The {tag, data} pair enters a shift pipeline of MEM_LATENCY stages.
- Completion timing: a load accepted in cycle n drives mem2proc_tag=tag and mem2proc_data=word during cycle n+MEM_LATENCY, for exactly one cycle.
- Cycles with no completion drive mem2proc_tag=0 and mem2proc_data=0.
- Throughput: one request accepted per cycle. Latency is fixed, so completions are in order and never collide.
  - At most MEM_LATENCY loads are outstanding.
  - MEM_LATENCY ≤ 14 therefore guarantees outstanding tags are unique.
- A completion and a new request in the same cycle are independent and both proceed.
- Reset mid-operation:
  - All in-flight loads are dropped and never complete.
  - The first request after reset deasserts receives tag 1.
  - Stores already accepted remain in storage.
- No backpressure: the requester must not assume completion of any request that saw response 0.

Test Plan:
1. Assert reset for 2 cycles, then release. → During reset, response=0, tag=0, data=0 even with BUS_LOAD applied. First load after release gets response=1.
2. Store 0x100 with data 0xDEADBEEF_CAFEF00D (response=1). Next cycle, load 0x100 (response=2). → Exactly 4 cycles after the load, tag=2 and data=0xDEADBEEF_CAFEF00D. Tag=0 on all surrounding cycles.
3. Store 0x11,0x22,0x33,0x44 to 0x0,0x8,0x10,0x18. Then issue back-to-back loads in cycles n..n+3. → Completions appear in cycles n+4..n+7 with consecutive tags, in order, with data 0x11..0x44.
4. Issue 15 consecutive accepted requests (tags 1..15). → The 16th request gets response=1; tag 0 is never issued. Then issue BUS_NONE and command 3. → Both give response=0 and the next request still gets the expected tag.
5. Accept 3 loads, then assert reset one cycle later. → No nonzero mem2proc_tag ever appears for those loads. First post-reset request gets tag 1. Earlier stored data is still readable.
6. Store 0xA5A5 to 0x100, then load 0x105. Separately, store to 0x2000 and load 0x0 (MEM_DEPTH_WORDS=1024). → The 0x105 load returns 0xA5A5 (same word). The 0x0 load returns the data stored to 0x2000 (address wrap).
